// File: rtl/pm_seq_pkg.sv
// Shared types and widths for the power-monitor scan sequencer.
package pm_seq_pkg;

  localparam int unsigned MAXCONVERTERS = 32;
  localparam int unsigned CH_W          = $clog2(MAXCONVERTERS);
  localparam int unsigned SETTLE_W      = $clog2(256);
  localparam int unsigned TMO_W         = $clog2(65536);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    COMPARE
  } seq_state_t;

  // Bits [n-1:0] set; the status registers never carry bits for absent rails.
  function automatic logic [MAXCONVERTERS-1:0] rail_mask(input int unsigned n);
    logic [MAXCONVERTERS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAXCONVERTERS; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/pm_window_compare.sv
// Strict window comparator: values equal to a threshold count as in-window.
module pm_window_compare #(
  parameter int unsigned DataWidth = 12
) (
  input  logic [DataWidth-1:0] d,
  input  logic [DataWidth-1:0] thr_uv_flt,
  input  logic [DataWidth-1:0] thr_uv_wrn,
  input  logic [DataWidth-1:0] thr_ov_wrn,
  input  logic [DataWidth-1:0] thr_ov_flt,
  output logic                 flt,
  output logic                 wrn
);

  always_comb begin
    flt = (d < thr_uv_flt) || (d > thr_ov_flt);
    wrn = (d < thr_uv_wrn) || (d > thr_ov_wrn);
  end

endmodule

// File: rtl/pm_scan_sequencer.sv
// Round-robin rail scanner: settles the mux, starts the ADC, window-checks each
// result and keeps live pgood plus latched warn/fault/timeout status.
module pm_scan_sequencer
  import pm_seq_pkg::*;
#(
  parameter int unsigned NumConverters = 8,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned DataWidth     = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_faults,
  output logic [4:0]           mux_sel,
  output logic                 soc,
  input  logic                 adc_eoc,
  input  logic [DataWidth-1:0] adc_data,
  input  logic [DataWidth-1:0] thr_uv_flt,
  input  logic [DataWidth-1:0] thr_uv_wrn,
  input  logic [DataWidth-1:0] thr_ov_wrn,
  input  logic [DataWidth-1:0] thr_ov_flt,
  output logic [31:0]          pgood_bus,
  output logic                 warn,
  output logic                 fault,
  output logic                 timeout,
  output logic                 eoc
);

  localparam logic [MAXCONVERTERS-1:0] VALID = rail_mask(NumConverters);

  seq_state_t               state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [SETTLE_W-1:0]      settle_q, settle_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [DataWidth-1:0]     data_q, data_d;
  logic                     skip_q, skip_d;
  logic [MAXCONVERTERS-1:0] pgood_q, pgood_d;
  logic [MAXCONVERTERS-1:0] fault_q, warn_q;
  logic [MAXCONVERTERS-1:0] fault_set, warn_set;
  logic                     timeout_q, timeout_set;
  logic                     eoc_q, eoc_d;
  logic [MAXCONVERTERS-1:0] ch_onehot;
  logic                     last_rail;
  logic                     cmp_flt, cmp_wrn;

  pm_window_compare #(
    .DataWidth(DataWidth)
  ) u_cmp (
    .d          (data_q),
    .thr_uv_flt (thr_uv_flt),
    .thr_uv_wrn (thr_uv_wrn),
    .thr_ov_wrn (thr_ov_wrn),
    .thr_ov_flt (thr_ov_flt),
    .flt        (cmp_flt),
    .wrn        (cmp_wrn)
  );

  assign ch_onehot = MAXCONVERTERS'(1) << ch_q;
  assign last_rail = (ch_q == CH_W'(NumConverters - 1));

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    skip_d      = skip_q;
    pgood_d     = pgood_q;
    fault_set   = '0;
    warn_set    = '0;
    timeout_set = 1'b0;
    eoc_d       = 1'b0;

    case (state_q)
      IDLE: begin
        ch_d = '0;
        if (enable) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_W'(SettleCycles - 1)) begin
          state_d = CONVERT;
          tmo_d   = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      CONVERT: begin
        // tmo_q==0 is the soc cycle; an eoc there is ignored. A real eoc beats
        // a timeout landing on the same cycle.
        if (adc_eoc && (tmo_q != '0)) begin
          data_d  = adc_data;
          skip_d  = 1'b0;
          state_d = COMPARE;
        end else if (tmo_q == TMO_W'(TimeoutCycles - 1)) begin
          timeout_set    = 1'b1;
          fault_set      = ch_onehot;
          pgood_d[ch_q]  = 1'b0;
          skip_d         = 1'b1;
          state_d        = COMPARE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      COMPARE: begin
        if (!skip_q) begin
          pgood_d[ch_q] = ~cmp_flt;
          fault_set     = cmp_flt ? ch_onehot : '0;
          warn_set      = cmp_wrn ? ch_onehot : '0;
        end
        if (last_rail) begin
          eoc_d = 1'b1;
          ch_d  = '0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
        if (enable) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else begin
          state_d = IDLE;
          ch_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      settle_q  <= '0;
      tmo_q     <= '0;
      data_q    <= '0;
      skip_q    <= 1'b0;
      pgood_q   <= '0;
      fault_q   <= '0;
      warn_q    <= '0;
      timeout_q <= 1'b0;
      eoc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      skip_q    <= skip_d;
      pgood_q   <= pgood_d & VALID;
      // Set-dominant: a bit being set this edge survives a simultaneous clear.
      fault_q   <= ((clear_faults ? '0 : fault_q) | fault_set) & VALID;
      warn_q    <= ((clear_faults ? '0 : warn_q) | warn_set) & VALID;
      timeout_q <= (clear_faults ? 1'b0 : timeout_q) | timeout_set;
      eoc_q     <= eoc_d;
    end
  end

  assign mux_sel   = ch_q;
  assign soc       = (state_q == CONVERT) && (tmo_q == '0);
  assign pgood_bus = pgood_q;
  assign warn      = |warn_q;
  assign fault     = |fault_q;
  assign timeout   = timeout_q;
  assign eoc       = eoc_q;

endmodule
